// File: rtl/array_unpacked_3d_fill.sv
// -----------------------------------------------------------------------------
// array_unpacked_3d_fill
//
// Sequential fill engine for a 3D unpacked array mem[SIZE_I][SIZE_J][SIZE_K]
// of WIDTH-bit elements. A start pulse in IDLE captures seed and walks every
// element in nested-loop order (k fastest, then j, then i). Each element gets
// seed + i + j + k (mod 2^WIDTH). One element is written per non-stalled
// cycle. A one-cycle done pulse follows the last write.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   start               begin a fill (only honoured in IDLE)
//   seed   [WIDTH]      base value, captured when start is accepted
//   stall               hold the current index and suppress the write
//   busy                high in FILL and DONE
//   done                one-cycle pulse after the last write
//   wr_vld              an element is written this cycle
//   wr_i/j/k           index presented to the array
//   wr_dat [WIDTH]      value presented to the array
//   rd_i/j/k           read address (out-of-range reads return 0)
//   rd_dat [WIDTH]      registered read data, one cycle latency
//
// Build option
//   ARRAY_UNPACKED_3D_FILL_CLEAR_EN : when defined, all storage elements are
//   cleared by rst_n. Otherwise storage has no reset and survives rst_n.
// -----------------------------------------------------------------------------
module array_unpacked_3d_fill #(
    parameter  int WIDTH  = 32,
    parameter  int SIZE_I = 4,
    parameter  int SIZE_J = 3,
    parameter  int SIZE_K = 2,
    localparam int IW     = (SIZE_I > 1) ? $clog2(SIZE_I) : 1,
    localparam int JW     = (SIZE_J > 1) ? $clog2(SIZE_J) : 1,
    localparam int KW     = (SIZE_K > 1) ? $clog2(SIZE_K) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             wr_vld,
    output logic [IW-1:0]    wr_i,
    output logic [JW-1:0]    wr_j,
    output logic [KW-1:0]    wr_k,
    output logic [WIDTH-1:0] wr_dat,
    input  logic [IW-1:0]    rd_i,
    input  logic [JW-1:0]    rd_j,
    input  logic [KW-1:0]    rd_k,
    output logic [WIDTH-1:0] rd_dat
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [IW-1:0]    i_q, i_d;
    logic [JW-1:0]    j_q, j_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] seed_q, seed_d;

    logic [WIDTH-1:0] mem_q [SIZE_I][SIZE_J][SIZE_K];
    logic [WIDTH-1:0] rd_sel;
    logic [WIDTH-1:0] rd_dat_q;

    logic i_last, j_last, k_last;

    assign i_last = (i_q == IW'(SIZE_I - 1));
    assign j_last = (j_q == JW'(SIZE_J - 1));
    assign k_last = (k_q == KW'(SIZE_K - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_FILL;
            ST_FILL: if (!stall && i_last && j_last && k_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_DONE);
        wr_vld = (state_q == ST_FILL) && !stall;
    end

    // ------------------------------------------------------------------
    // Index counters and captured seed
    // ------------------------------------------------------------------
    // After the final write all three counters wrap back to zero, so IDLE
    // and DONE present index (0,0,0) and wr_dat shows the captured seed.
    always_comb begin
        i_d    = i_q;
        j_d    = j_q;
        k_d    = k_q;
        seed_d = seed_q;
        if (state_q == ST_IDLE && start) begin
            seed_d = seed;
            i_d    = '0;
            j_d    = '0;
            k_d    = '0;
        end else if (wr_vld) begin
            if (!k_last) begin
                k_d = k_q + KW'(1);
            end else begin
                k_d = '0;
                if (!j_last) begin
                    j_d = j_q + JW'(1);
                end else begin
                    j_d = '0;
                    i_d = i_last ? '0 : i_q + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            seed_q <= '0;
        end else begin
            i_q    <= i_d;
            j_q    <= j_d;
            k_q    <= k_d;
            seed_q <= seed_d;
        end
    end

    // Indices are resized to WIDTH before the add. Truncating a wider index
    // does not change the result modulo 2^WIDTH, so the carry-out is simply
    // dropped.
    assign wr_i   = i_q;
    assign wr_j   = j_q;
    assign wr_k   = k_q;
    assign wr_dat = seed_q + WIDTH'(i_q) + WIDTH'(j_q) + WIDTH'(k_q);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // Elements are selected by comparing against constant loop indices,
    // which keeps non-power-of-two dimensions safe without index padding.
`ifdef ARRAY_UNPACKED_3D_FILL_CLEAR_EN
    // NOTE: clearing a memory on reset turns every element into a resettable
    // flop; only this build option pays for it, the default build has no
    // storage reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE_I; i++)
                for (int j = 0; j < SIZE_J; j++)
                    for (int k = 0; k < SIZE_K; k++)
                        mem_q[i][j][k] <= '0;
        end else if (wr_vld) begin
            for (int i = 0; i < SIZE_I; i++)
                for (int j = 0; j < SIZE_J; j++)
                    for (int k = 0; k < SIZE_K; k++)
                        if (i_q == IW'(i) && j_q == JW'(j) && k_q == KW'(k))
                            mem_q[i][j][k] <= wr_dat;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            for (int i = 0; i < SIZE_I; i++)
                for (int j = 0; j < SIZE_J; j++)
                    for (int k = 0; k < SIZE_K; k++)
                        if (i_q == IW'(i) && j_q == JW'(j) && k_q == KW'(k))
                            mem_q[i][j][k] <= wr_dat;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    // No element matches an out-of-range address, so the default 0 is
    // returned. Reading the element being written yields its old value
    // because the array and rd_dat_q update on the same edge.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < SIZE_I; i++)
            for (int j = 0; j < SIZE_J; j++)
                for (int k = 0; k < SIZE_K; k++)
                    if (rd_i == IW'(i) && rd_j == JW'(j) && rd_k == KW'(k))
                        rd_sel = mem_q[i][j][k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_sel;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: tb/tb_array_unpacked_3d_fill.sv
module tb_array_unpacked_3d_fill;

    localparam int W  = 32;
    localparam int SI = 4;
    localparam int SJ = 3;
    localparam int SK = 2;
    localparam int N  = SI * SJ * SK;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic         start = 1'b0, stall = 1'b0;
    logic [W-1:0] seed = '0;
    logic         busy, done, wr_vld;
    logic [1:0]   wr_i, wr_j;
    logic [0:0]   wr_k;
    logic [W-1:0] wr_dat, rd_dat;
    logic [1:0]   rd_i = '0, rd_j = '0;
    logic [0:0]   rd_k = '0;

    array_unpacked_3d_fill dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .stall(stall),
        .busy(busy), .done(done), .wr_vld(wr_vld),
        .wr_i(wr_i), .wr_j(wr_j), .wr_k(wr_k), .wr_dat(wr_dat),
        .rd_i(rd_i), .rd_j(rd_j), .rd_k(rd_k), .rd_dat(rd_dat)
    );

    // 8-bit instance for modular wrap of the value
    logic       start8 = 1'b0, stall8 = 1'b0;
    logic [7:0] seed8 = '0;
    logic       busy8, done8, wr_vld8;
    logic [1:0] wr_i8, wr_j8;
    logic [0:0] wr_k8;
    logic [7:0] wr_dat8, rd_dat8;
    logic [1:0] rd_i8 = '0, rd_j8 = '0;
    logic [0:0] rd_k8 = '0;

    array_unpacked_3d_fill #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .seed(seed8), .stall(stall8),
        .busy(busy8), .done(done8), .wr_vld(wr_vld8),
        .wr_i(wr_i8), .wr_j(wr_j8), .wr_k(wr_k8), .wr_dat(wr_dat8),
        .rd_i(rd_i8), .rd_j(rd_j8), .rd_k(rd_k8), .rd_dat(rd_dat8)
    );

    // Degenerate 1x1x1 instance
    logic       start1 = 1'b0, stall1 = 1'b0;
    logic [7:0] seed1 = '0;
    logic       busy1, done1, wr_vld1;
    logic [0:0] wr_i1, wr_j1, wr_k1;
    logic [7:0] wr_dat1, rd_dat1;
    logic [0:0] rd_i1 = '0, rd_j1 = '0, rd_k1 = '0;

    array_unpacked_3d_fill #(.WIDTH(8), .SIZE_I(1), .SIZE_J(1), .SIZE_K(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed1), .stall(stall1),
        .busy(busy1), .done(done1), .wr_vld(wr_vld1),
        .wr_i(wr_i1), .wr_j(wr_j1), .wr_k(wr_k1), .wr_dat(wr_dat1),
        .rd_i(rd_i1), .rd_j(rd_j1), .rd_k(rd_k1), .rd_dat(rd_dat1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the ordered list of writes a fill must produce and
    // the array contents those writes leave behind.
    typedef struct {
        int           i;
        int           j;
        int           k;
        logic [W-1:0] d;
    } wr_t;

    wr_t          exp_q[$];
    wr_t          plan[$];
    logic [W-1:0] model_mem [SI][SJ][SK];
    bit           model_ok  [SI][SJ][SK];

    function automatic void build_plan(input logic [W-1:0] s);
        plan.delete();
        for (int i = 0; i < SI; i++)
            for (int j = 0; j < SJ; j++)
                for (int k = 0; k < SK; k++)
                    plan.push_back('{i, j, k, s + W'(i + j + k)});
    endfunction

    function automatic void apply_write(input wr_t e);
        model_mem[e.i][e.j][e.k] = e.d;
        model_ok[e.i][e.j][e.k]  = 1'b1;
    endfunction

    // Monitor: every observed write is matched against the next expected one
    always @(negedge clk) begin
        if (rst_n && wr_vld) begin
            wr_t e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got (%0d,%0d,%0d)=%0h, expected no write",
                         wr_i, wr_j, wr_k, wr_dat);
            end else begin
                e = exp_q.pop_front();
                check("wr_i",   64'(wr_i),   64'(e.i));
                check("wr_j",   64'(wr_j),   64'(e.j));
                check("wr_k",   64'(wr_k),   64'(e.k));
                check("wr_dat", 64'(wr_dat), 64'(e.d));
            end
        end
    end

    // mode: 0 no stall, 1 three stall cycles after the 5th write, 2 random
    // noise: random start/seed during FILL and a start pulse in DONE
    // rdw: check read-during-write of element (0,0,0)
    task automatic run_fill(input logic [W-1:0] s, input int mode, input bit noise, input bit rdw);
        int           writes;
        int           cyc;
        int           stall_run;
        logic [W-1:0] old00;
        build_plan(s);
        foreach (plan[p]) exp_q.push_back(plan[p]);
        old00 = model_mem[0][0][0];
        if (rdw) begin
            rd_i = '0; rd_j = '0; rd_k = '0;
        end
        @(posedge clk); #1;
        start = 1'b1;
        seed  = s;
        @(posedge clk); #1;
        start = 1'b0;
        writes = 0; cyc = 0; stall_run = 0;
        while (writes < N && cyc < 4 * N + 20) begin
            case (mode)
                1:       stall = (writes == 5 && stall_run < 3);
                2:       stall = ($urandom_range(3) == 0);
                default: stall = 1'b0;
            endcase
            if (rdw && cyc < 2) stall = 1'b0;
            if (noise) begin
                start = 1'($urandom_range(1));
                seed  = $urandom;
            end
            @(negedge clk);
            check("fill_busy",   64'(busy),   64'(1));
            check("fill_done",   64'(done),   64'(0));
            check("fill_wr_vld", 64'(wr_vld), 64'(!stall));
            if (stall) begin
                check("hold_i", 64'(wr_i), 64'(plan[writes].i));
                check("hold_j", 64'(wr_j), 64'(plan[writes].j));
                check("hold_k", 64'(wr_k), 64'(plan[writes].k));
                stall_run++;
            end
            if (rdw && cyc == 1) check("rdw_old", 64'(rd_dat), 64'(old00));
            if (rdw && cyc == 2) check("rdw_new", 64'(rd_dat), 64'(plan[0].d));
            if (!stall) begin
                apply_write(plan[writes]);
                writes++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        if (writes < N) begin
            n_checks++;
            n_fail++;
            $display("FAIL fill_timeout: got %0d writes, expected %0d", writes, N);
        end
        if (mode == 1) check("stall_cycles", 64'(cyc), 64'(N + 3));
        // DONE cycle: stall and start must have no effect here
        stall = 1'($urandom_range(1));
        if (noise) begin
            start = 1'b1;
            seed  = $urandom;
        end
        @(negedge clk);
        check("done_pulse",  64'(done),   64'(1));
        check("done_busy",   64'(busy),   64'(1));
        check("done_wr_vld", 64'(wr_vld), 64'(0));
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("idle_done",   64'(done),   64'(0));
        check("idle_busy",   64'(busy),   64'(0));
        check("idle_wr_vld", 64'(wr_vld), 64'(0));
        check("sb_empty",    64'(exp_q.size()), 64'(0));
    endtask

    task automatic read_chk(input int i, input int j, input int k,
                            input logic [W-1:0] exp, input string name);
        @(posedge clk); #1;
        rd_i = 2'(i); rd_j = 2'(j); rd_k = 1'(k);
        @(posedge clk);
        @(negedge clk);
        check(name, 64'(rd_dat), 64'(exp));
    endtask

    task automatic read_model();
        for (int i = 0; i < SI; i++)
            for (int j = 0; j < SJ; j++)
                for (int k = 0; k < SK; k++)
                    if (model_ok[i][j][k]) read_chk(i, j, k, model_mem[i][j][k], "readback");
    endtask

    task automatic idle_stall();
        @(posedge clk); #1;
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_stall_busy", 64'(busy),   64'(0));
            check("idle_stall_vld",  64'(wr_vld), 64'(0));
        end
        @(posedge clk); #1;
        stall = 1'b0;
    endtask

    task automatic abort_fill(input logic [W-1:0] s, input int nw);
        build_plan(s);
        foreach (plan[p]) exp_q.push_back(plan[p]);
        @(posedge clk); #1;
        start = 1'b1;
        seed  = s;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < nw; c++) begin
            @(negedge clk);
            check("abort_wr_vld", 64'(wr_vld), 64'(1));
            apply_write(plan[c]);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("rst_busy",   64'(busy),   64'(0));
        check("rst_done",   64'(done),   64'(0));
        check("rst_wr_vld", 64'(wr_vld), 64'(0));
        check("rst_wr_idx", 64'({wr_i, wr_j, wr_k}), 64'(0));
        check("rst_wr_dat", 64'(wr_dat), 64'(0));
        check("rst_rd_dat", 64'(rd_dat), 64'(0));
        exp_q.delete();
`ifdef ARRAY_UNPACKED_3D_FILL_CLEAR_EN
        for (int i = 0; i < SI; i++)
            for (int j = 0; j < SJ; j++)
                for (int k = 0; k < SK; k++)
                    apply_write('{i, j, k, '0});
`endif
        repeat (2) begin
            @(negedge clk);
            check("rst_no_done", 64'(done), 64'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        read_chk(0, 0, 0, model_mem[0][0][0], "post_reset_000");
    endtask

    task automatic run_width8();
        logic [7:0] e;
        int         c;
        @(posedge clk); #1;
        start8 = 1'b1;
        seed8  = 8'hFE;
        @(posedge clk); #1;
        start8 = 1'b0;
        seed8  = 8'h00;
        c = 0;
        while (!done8 && c < 4 * N) begin
            @(negedge clk);
            c++;
        end
        check("w8_done", 64'(done8), 64'(1));
        for (int i = 0; i < SI; i++)
            for (int j = 0; j < SJ; j++)
                for (int k = 0; k < SK; k++) begin
                    @(posedge clk); #1;
                    rd_i8 = 2'(i); rd_j8 = 2'(j); rd_k8 = 1'(k);
                    @(posedge clk);
                    @(negedge clk);
                    e = 8'hFE + 8'(i + j + k);
                    check("w8_read", 64'(rd_dat8), 64'(e));
                    if (i == 0 && j == 0 && k == 0) check("w8_000", 64'(rd_dat8), 64'h0FE);
                    if (i == 0 && j == 0 && k == 1) check("w8_001", 64'(rd_dat8), 64'h0FF);
                    if (i == 0 && j == 1 && k == 1) check("w8_011", 64'(rd_dat8), 64'h000);
                    if (i == 3 && j == 2 && k == 1) check("w8_321", 64'(rd_dat8), 64'h004);
                end
    endtask

    task automatic run_single();
        @(posedge clk); #1;
        start1 = 1'b1;
        seed1  = 8'd7;
        @(posedge clk); #1;
        start1 = 1'b0;
        seed1  = 8'h55;
        @(negedge clk);
        check("s1_wr_vld", 64'(wr_vld1), 64'(1));
        check("s1_wr_dat", 64'(wr_dat1), 64'(7));
        check("s1_wr_idx", 64'({wr_i1, wr_j1, wr_k1}), 64'(0));
        check("s1_no_done", 64'(done1), 64'(0));
        @(negedge clk);
        check("s1_done",     64'(done1),   64'(1));
        check("s1_done_vld", 64'(wr_vld1), 64'(0));
        @(negedge clk);
        check("s1_idle", 64'(busy1), 64'(0));
        check("s1_read", 64'(rd_dat1), 64'(7));
    endtask

    initial begin
        for (int i = 0; i < SI; i++)
            for (int j = 0; j < SJ; j++)
                for (int k = 0; k < SK; k++)
                    model_ok[i][j][k] = 1'b0;

        #2;
        check("reset_busy",   64'(busy),   64'(0));
        check("reset_done",   64'(done),   64'(0));
        check("reset_wr_vld", 64'(wr_vld), 64'(0));
        check("reset_wr_idx", 64'({wr_i, wr_j, wr_k}), 64'(0));
        check("reset_wr_dat", 64'(wr_dat), 64'(0));
        check("reset_rd_dat", 64'(rd_dat), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        idle_stall();

        run_fill(32'd0, 0, 1'b0, 1'b0);
        read_chk(3, 2, 1, 32'd6, "seed0_321");
        read_chk(1, 2, 0, 32'd3, "seed0_120");
        read_model();

        run_fill(32'hA5A5_0001, 0, 1'b0, 1'b1);
        run_fill(32'd0, 1, 1'b1, 1'b1);
        read_chk(3, 2, 1, 32'd6, "stall_321");
        read_chk(0, 2, 1, 32'd3, "stall_021");
        read_model();

        for (int r = 0; r < 4; r++) run_fill($urandom, 2, 1'b1, 1'b1);
        read_model();
        read_chk(1, 3, 0, 32'd0, "oob_read");

        abort_fill(32'h0BAD_F00D, 9);

        run_width8();
        run_single();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound so the run always terminates
    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: got no summary, expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/array_unpacked_3d_fill.md
# array_unpacked_3d_fill

Parametrised sequential fill engine for a 3D unpacked storage array `mem[SIZE_I-1:0][SIZE_J-1:0][SIZE_K-1:0]` of WIDTH-bit elements. On a start pulse it visits every element in nested-loop order with k fastest, then j, then i. It writes `seed + i + j + k` at one element per non-stalled cycle, then pulses done. It is the synthesizable, stallable, seedable generalisation of the fixed 4x3x2 int array waveform examples, and exposes a write-observation port and a registered read port for waveform-dump and checker benches.

## Interface
- WIDTH, 32, element width in bits (≥1)
- SIZE_I, 4, outer dimension (≥1)
- SIZE_J, 3, middle dimension (≥1)
- SIZE_K, 2, inner dimension (≥1)
- Derived: IW/JW/KW = max(1, $clog2(SIZE_x)), index widths

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin fill; sampled only in IDLE
- seed  in  WIDTH  base value, captured when start is accepted
- stall  in  1  hold current index, suppress write
- busy  out  1  high in FILL and DONE
- done  out  1  one-cycle pulse after the last write
- wr_vld  out  1  element written this cycle
- wr_i / wr_j / wr_k  out  IW/JW/KW  index being written
- wr_dat  out  WIDTH  value being written
- rd_i / rd_j / rd_k  in  IW/JW/KW  read address
- rd_dat  out  WIDTH  registered read data

## Operation
- States: IDLE, FILL, DONE.
- IDLE to FILL on start. Seed is captured, and counters i=j=k=0.
- FILL with stall=0: write `mem[i][j][k]`, assert wr_vld, then advance. k increments. On k=SIZE_K-1, k wraps to 0 and j increments. On j=SIZE_J-1, j wraps and i increments.
- FILL with stall=1: no write, wr_vld=0, indices held.
- The write at (SIZE_I-1, SIZE_J-1, SIZE_K-1) moves FILL to DONE. DONE lasts exactly one cycle with done=1, then returns to IDLE.
- Value: `(seed_q + i + j + k) mod 2^WIDTH`. Indices are zero-extended before the add, and the carry is discarded.
- wr_i/j/k and wr_dat are driven combinationally from the counters and seed_q. When wr_vld=0 they show the held or zeroed counter state.
- start while busy: ignored; no restart, and seed is not recaptured.
- start in the DONE cycle: ignored. A new start is accepted from the next IDLE cycle.
- Read port: rd_dat is `mem[rd_i][rd_j][rd_k]` registered, so latency is 1 cycle.
  - Read and write of the same element in one cycle returns the old value.
  - An out-of-range read index returns 0.
- Storage is not cleared by start. Elements are only overwritten by fills.

## Timing
- Reset values: busy=0, done=0, wr_vld=0, wr_i/j/k=0, wr_dat=0, rd_dat=0. State is IDLE, and seed_q=0.
- Reset is asynchronous and may assert mid-fill. The block returns to IDLE immediately and no done is issued. Storage content follows Configuration.
- Start accepted at edge n: the first write happens in cycle n+1.
- With no stalls, writes occupy cycles n+1 through n+N, where N=SIZE_I·SIZE_J·SIZE_K. done is high in cycle n+N+1.
- Each stalled FILL cycle delays done by one cycle.
- A stall in IDLE or DONE has no effect.
- Degenerate case SIZE_I=SIZE_J=SIZE_K=1: one write in cycle n+1, done in cycle n+2.

## Configuration
- ARRAY_UNPACKED_3D_FILL_CLEAR_EN
  - Defined: all storage elements reset asynchronously to 0 with rst_n. Reads of never-written elements return 0.
  - Undefined: storage has no reset. Contents survive rst_n assertion, and reads of never-written elements are undefined (X in simulation).
- Control and output reset behaviour is identical in both builds.

## Test plan
- Default params, seed=0, start at cycle 0, no stall. Required response:
  - 24 wr_vld cycles in order (0,0,0), (0,0,1), (0,1,0) … (3,2,1).
  - done in cycle 25.
  - Readback gives [3][2][1]=6 and [1][2][0]=3.
- Stall high for 3 cycles after the 5th write: indices hold at (0,2,1), and done moves to cycle 28. Final contents are identical to the no-stall run.
- WIDTH=8, seed=8'hFE: [0][0][0]=FE, [0][0][1]=FF, [0][1][1]=00, [3][2][1]=04.
- Pulse start again in cycles 3 and 25 (the DONE cycle) with a different seed: both pulses are ignored, and contents still match the first seed.
- Deassert rst_n at cycle 10 mid-fill: all outputs go to 0 at once, with no done. Readback of [0][0][0]:
  - With ARRAY_UNPACKED_3D_FILL_CLEAR_EN: 0.
  - Without it: the prior value.
- SIZE_I=SIZE_J=SIZE_K=1, seed=7: one write of 7 in cycle 1, done in cycle 2. Reading (0,0,0) returns 7 one cycle later.
